// File: rtl/pipe_trace_monitor_pkg.sv
// pipe_trace_pkg: MIPS32 opcode/funct constants and the retire classifier
package pipe_trace_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2a;
  localparam logic [31:0] NOP = '0;
  typedef enum logic [1:0] {CLS_NONE, CLS_ALU, CLS_MEM, CLS_BRANCH} cls_e;
  function automatic cls_e instr_class(input logic [5:0] op, input logic [5:0] fn, input logic nz);
    logic alu_fn;
    alu_fn = fn inside {FN_SLL, FN_SRL, FN_SLLV, FN_SRLV, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
    return !nz ? CLS_NONE :
           (op == OP_LW || op == OP_SW) ? CLS_MEM :
           (op == OP_BEQ || op == OP_BNE) ? CLS_BRANCH :
           ((op == OP_RTYPE && alu_fn) || op == OP_ADDI) ? CLS_ALU : CLS_NONE;
  endfunction
endpackage

// File: rtl/pipe_trace_monitor_if.sv
// pipe_trace_monitor_if: core-side pipeline taps plus the trace FIFO read port
interface pipe_trace_monitor_if #(parameter int STAGES = 5, PC_W = 32, INSTR_W = 32);
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] if_instr, id_instr;
  logic stall;
  logic [STAGES*INSTR_W-1:0] stage_instr;
  logic rd_en;
  logic [PC_W+INSTR_W-1:0] rd_data;
  logic empty, full, overflow;
  modport master (output pc, if_instr, id_instr, rd_en, input stall, stage_instr, rd_data, empty, full, overflow);
  modport slave (input pc, if_instr, id_instr, rd_en, output stall, stage_instr, rd_data, empty, full, overflow);
endinterface

// File: rtl/pipe_trace_monitor_fifo.sv
// trace_fifo: first-word-fall-through FIFO with a sticky drop flag
module trace_fifo #(parameter int WIDTH = 64, DEPTH = 16) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop frees the head slot in the same edge, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= overflow || (push && !do_push);
    end
endmodule

// File: rtl/pipe_trace_monitor.sv
// pipe_trace_monitor: shadows PC/instr through the pipe, counts events, traces retires
module pipe_trace_monitor import pipe_trace_pkg::*; #(
  parameter int STAGES = 5, PC_W = 32, INSTR_W = 32, TRACE_DEPTH = 16, CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  pipe_trace_monitor_if.slave bus,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] branch_cnt
);
  logic [PC_W-1:0] pc_prv;
  logic pc_valid, stall, retire;
  logic [INSTR_W-1:0] slot_q [2:STAGES-1];
  logic [PC_W-1:0] pc_q [2:STAGES-1];
  logic [STAGES*INSTR_W-1:0] stage;
  cls_e cls;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction
  assign stall = pc_valid && bus.pc == pc_prv;
  assign retire = slot_q[STAGES-1] != INSTR_W'(NOP);
  assign cls = instr_class(slot_q[STAGES-1][31:26], slot_q[STAGES-1][5:0], retire);
  always_comb begin
    stage = '0;
    stage[0 +: INSTR_W] = bus.if_instr;
    stage[INSTR_W +: INSTR_W] = bus.id_instr;
    for (int k = 2; k < STAGES; k++) stage[k*INSTR_W +: INSTR_W] = slot_q[k];
  end
  assign bus.stall = stall;
  assign bus.stage_instr = stage;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pc_prv <= '0;
      pc_valid <= 1'b0;
      for (int k = 2; k < STAGES; k++) begin
        slot_q[k] <= '0;
        pc_q[k] <= '0;
      end
      cycle_cnt <= '0;
      retire_cnt <= '0;
      stall_cnt <= '0;
      mem_cnt <= '0;
      branch_cnt <= '0;
    end else begin
      pc_prv <= bus.pc;
      pc_valid <= 1'b1;
      // the IF/ID word of a stalled fetch is a repeat, so it enters EX as a bubble
      slot_q[2] <= stall ? INSTR_W'(NOP) : bus.id_instr;
      pc_q[2] <= pc_prv;
      for (int k = 3; k < STAGES; k++) begin
        slot_q[k] <= slot_q[k-1];
        pc_q[k] <= pc_q[k-1];
      end
      cycle_cnt <= sat_inc(cycle_cnt, 1'b1);
      retire_cnt <= sat_inc(retire_cnt, retire);
      stall_cnt <= sat_inc(stall_cnt, stall);
      mem_cnt <= sat_inc(mem_cnt, cls == CLS_MEM);
      branch_cnt <= sat_inc(branch_cnt, cls == CLS_BRANCH);
    end
  trace_fifo #(.WIDTH(PC_W + INSTR_W), .DEPTH(TRACE_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (retire),
    .din      ({pc_q[STAGES-1], slot_q[STAGES-1]}),
    .pop      (bus.rd_en),
    .dout     (bus.rd_data),
    .empty    (bus.empty),
    .full     (bus.full),
    .overflow (bus.overflow)
  );
endmodule

// File: tb/tb_pipe_trace_monitor.sv
// tb_pipe_trace_monitor: directed run with a retire scoreboard; second instance checks saturation
module tb_pipe_trace_monitor;
  localparam int ST = 5, PW = 32, IW = 32, TD = 4;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;
  pipe_trace_monitor_if #(.STAGES(ST), .PC_W(PW), .INSTR_W(IW)) bus (), sbus ();
  logic [31:0] cyc, ret, stl, mem, br;
  logic [3:0] s_cyc, s_ret, s_stl, s_mem, s_br;
  assign sbus.pc = bus.pc;
  assign sbus.if_instr = bus.if_instr;
  assign sbus.id_instr = bus.id_instr;
  assign sbus.rd_en = bus.rd_en;
  pipe_trace_monitor #(.STAGES(ST), .PC_W(PW), .INSTR_W(IW), .TRACE_DEPTH(TD), .CNT_W(32)) u_dut (
    .clock(clock), .reset(reset), .bus(bus),
    .cycle_cnt(cyc), .retire_cnt(ret), .stall_cnt(stl), .mem_cnt(mem), .branch_cnt(br));
  pipe_trace_monitor #(.STAGES(ST), .PC_W(PW), .INSTR_W(IW), .TRACE_DEPTH(TD), .CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .bus(sbus),
    .cycle_cnt(s_cyc), .retire_cnt(s_ret), .stall_cnt(s_stl), .mem_cnt(s_mem), .branch_cnt(s_br));
  int n_tests = 0, n_fail = 0;
  int n_ret = 0, n_mem = 0, n_br = 0, n_stall = 0, n_ticks = 0;
  logic [63:0] q [$];
  logic [31:0] last_pc = 0, last_if = 0, pcv = 0;
  bit valid_b = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] slot(input int k);
    return bus.stage_instr[k*IW +: IW];
  endfunction
  function automatic logic [31:0] prog(input int i);
    case (i % 8)
      0: return 32'h00221820;
      1: return 32'h8c220000;
      2: return 32'hac220004;
      3: return 32'h1422fffe;
      4: return 32'h8c230008;
      5: return 32'hac23000c;
      6: return 32'h20210001;
      default: return 32'h1022fffe;
    endcase
  endfunction
  // one cycle: fetch ins at p, pop the head if asked, record what ID will carry into EX
  task automatic tick(input logic [31:0] p, input logic [31:0] ins, input bit drain);
    logic exp_stall;
    exp_stall = valid_b && p == last_pc;
    bus.pc = p;
    bus.if_instr = ins;
    bus.id_instr = last_if;
    bus.rd_en = drain && !bus.empty;
    #1;
    chk("stall", bus.stall, exp_stall);
    if (bus.rd_en) begin
      if (q.size() == 0) chk("unexpected_entry", bus.empty, 1);
      else chk("trace", bus.rd_data, q.pop_front());
    end
    if (exp_stall) n_stall++;
    else if (last_if != 0) begin
      q.push_back({last_pc, last_if});
      n_ret++;
      if (last_if[31:26] == 6'h23 || last_if[31:26] == 6'h2b) n_mem++;
      if (last_if[31:26] == 6'h04 || last_if[31:26] == 6'h05) n_br++;
    end
    last_pc = p;
    last_if = ins;
    valid_b = 1;
    @(posedge clock);
    #1;
    n_ticks++;
  endtask
  task automatic run(input logic [31:0] ins, input bit drain);
    tick(pcv, ins, drain);
    pcv += 4;
  endtask
  initial begin
    bus.pc = 0;
    bus.if_instr = 0;
    bus.id_instr = 0;
    bus.rd_en = 0;
    #22;
    chk("rst_cycle", cyc, 0);
    chk("rst_retire", ret, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    reset = 1;
    // straight-line flow with continuous draining
    for (int i = 0; i < 4; i++) run(prog(i), 1);
    chk("first_in_slot4", slot(4), prog(0));
    chk("retire_before", ret, 0);
    chk("empty_before", bus.empty, 1);
    run(prog(4), 1);
    chk("first_retire", ret, 1);
    chk("first_head", bus.rd_data, {32'd0, prog(0)});
    for (int i = 5; i < 11; i++) run(prog(i), 1);
    tick(pcv - 4, prog(10), 1);
    chk("stall_bubble", slot(2), 0);
    chk("stall_cnt", stl, 1);
    for (int i = 11; i < 15; i++) run(prog(i), 1);
    for (int i = 0; i < 8; i++) run(0, 1);
    chk("a_empty", bus.empty, 1);
    chk("a_retire", ret, n_ret);
    chk("a_mem", mem, n_mem);
    chk("a_branch", br, n_br);
    chk("a_stall", stl, n_stall);
    chk("a_cycle", cyc, n_ticks);
    chk("a_overflow", bus.overflow, 0);
    // overflow: six retires, no reads
    for (int i = 1; i < 7; i++) run(prog(i), 0);
    for (int i = 0; i < 5; i++) run(0, 0);
    chk("b_full", bus.full, 1);
    chk("b_overflow", bus.overflow, 1);
    chk("b_retire", ret, n_ret);
    chk("b_mem", mem, n_mem);
    while (q.size() > TD) void'(q.pop_back());
    for (int i = 0; i < TD; i++) run(0, 1);
    chk("b_empty", bus.empty, 1);
    // reset mid-run
    for (int i = 0; i < 10; i++) run(prog(i), 1);
    reset = 0;
    #15;
    reset = 1;
    chk("r_cycle", cyc, 0);
    chk("r_retire", ret, 0);
    chk("r_stall_cnt", stl, 0);
    chk("r_mem", mem, 0);
    chk("r_branch", br, 0);
    chk("r_empty", bus.empty, 1);
    chk("r_full", bus.full, 0);
    chk("r_overflow", bus.overflow, 0);
    chk("r_stall", bus.stall, 0);
    for (int k = 2; k < ST; k++) chk("r_slot", slot(k), 0);
    q.delete();
    n_ret = 0; n_mem = 0; n_br = 0; n_stall = 0; n_ticks = 0;
    last_if = 0;
    valid_b = 0;
    // fill, then push and pop together while full
    for (int i = 0; i < TD; i++) run(prog(i), 0);
    run(32'h00221822, 0);
    for (int i = 0; i < 3; i++) run(0, 0);
    chk("c_full_before", bus.full, 1);
    run(0, 1);
    chk("c_full_after", bus.full, 1);
    chk("c_overflow", bus.overflow, 0);
    for (int i = 0; i < TD; i++) run(0, 1);
    chk("c_empty", bus.empty, 1);
    for (int i = 0; i < 12; i++) run(0, 0);
    chk("c_retire", ret, n_ret);
    chk("c_mem", mem, n_mem);
    chk("c_branch", br, n_br);
    chk("c_stall", stl, n_stall);
    chk("c_cycle", cyc, n_ticks);
    chk("sat_cycle", s_cyc, 15);
    chk("sat_retire", s_ret, n_ret);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_trace_monitor.md
Name: pipe_trace_monitor

Overview:
- Synthesizable, parametrised pipeline tracker for the MIPS32 core. Successor to the fixed 5-stage instruction-string tracker.
- Shadows PC/instruction through STAGES pipeline slots and detects fetch stalls (PC unchanged).
- Keeps saturating cycle/retire/stall/class counters and pushes every retired instruction into a first-word-fall-through (FWFT) trace FIFO, for the bench or a debug port to drain.

Parameters:
STAGES, 5, pipeline depth tracked (IF..WB); legal 3..8
PC_W, 32, PC width
INSTR_W, 32, instruction width (opcode = [31:26], funct = [5:0])
TRACE_DEPTH, 16, trace FIFO entries; power of two, >= 2
CNT_W, 32, width of every counter

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low; clears all state
pc  input  PC_W  current fetch PC (core PC)
if_instr  input  INSTR_W  instruction in IF
id_instr  input  INSTR_W  IF/ID register instruction
stall  output  1  high in cycles where pc == previous pc (after first valid cycle)
stage_instr  output  STAGES*INSTR_W  per-stage instruction; slot 0 = IF, slot STAGES-1 = retiring
rd_en  input  1  pop trace head
rd_data  output  PC_W+INSTR_W  {pc, instr} of FIFO head; valid when !empty
empty  output  1  FIFO empty
full  output  1  FIFO full
overflow  output  1  sticky: a retire was dropped because FIFO was full
cycle_cnt  output  CNT_W  cycles since reset release
retire_cnt  output  CNT_W  non-zero instructions retired
stall_cnt  output  CNT_W  stall cycles
mem_cnt  output  CNT_W  retired LW/SW
branch_cnt  output  CNT_W  retired BEQ/BNE

Behaviour:
- Reset (reset=0, async):
  - All counters, FIFO pointers, stage registers and pc_prv cleared.
  - pc_valid=0, overflow=0, stall=0, empty=1, full=0.
  - rd_data = 0 while empty.
- Stage slots:
  - slot0 = if_instr and slot1 = id_instr (combinational).
  - Slots 2..STAGES-1 are registers shifting each posedge: slot2 <= (stall ? 0 : slot1); slotk <= slot(k-1).
  - Each slot carries its PC:
    - pc1 = pc_prv.
    - pc2 <= pc1.
    - pck <= pc(k-1).
  - Instruction value 0 = bubble/NOP.
- Stall detection:
  - pc_prv <= pc every cycle.
  - pc_valid <= 1 on the first posedge after reset release.
  - stall = pc_valid && (pc == pc_prv), combinational.
- Retire:
  - A cycle retires when slot STAGES-1 is non-zero.
  - Effect of that same posedge:
    - retire_cnt increments.
    - mem_cnt increments if opcode is 100011 or 101011.
    - branch_cnt increments if opcode is 000100 or 000101.
    - {pc(STAGES-1), slot(STAGES-1)} is pushed into the FIFO.
- Counters:
  - cycle_cnt increments every posedge while reset=1.
  - stall_cnt increments on posedges where stall=1.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Trace FIFO:
  - FWFT: rd_data shows the head while !empty.
  - rd_en with empty=1 is ignored, with no state change.
  - Push while full without pop: entry dropped, overflow set (sticky until reset), retire_cnt still increments.
  - Push and pop in the same cycle while full: both succeed; occupancy unchanged; overflow unchanged.
  - Push and pop in the same cycle while empty: the push lands; the pop is ignored.
  - Pointers wrap modulo TRACE_DEPTH; occupancy counter is log2(TRACE_DEPTH)+1 bits.
- Reset asserted mid-operation discards all FIFO contents and pipeline slots immediately. No partial retire.
- Latency:
  - An instruction in slot1 at cycle n is in slot STAGES-1 at cycle n+STAGES-2 (absent stalls).
  - It is readable at rd_data one cycle after its retire posedge.

Decomposition:
- Package pipe_trace_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI.
  - funct constants for SLL/SRL/SLLV/SRLV/ADD/SUB/AND/OR/NOR/SLT.
  - NOP value 0.
  - Instruction-class enum {CLS_NONE, CLS_ALU, CLS_MEM, CLS_BRANCH}.
  - Classifier function instr_class().
- Sub-module trace_fifo (parametrised WIDTH, DEPTH, FWFT, with full/empty/overflow).
- The top holds the stage shift chain, stall logic and counters.

Test Plan:
- Reset mid-run: drive 10 non-zero instrs, assert reset for 1.5 cycles -> all counters 0, empty=1, overflow=0, slots 2..4 zero.
- Straight-line flow: STAGES=5, PCs 0,4,8,… with ADD/LW/SW -> first retire 3 cycles after it is in id_instr; rd_data = {16, LW word} for the LW fetched at PC 16; mem_cnt counts 2 per LW+SW pair.
- Stall: hold pc at 40 for one extra cycle -> stall=1 for exactly that cycle; slot2 gets 0 next cycle; stall_cnt=1; the bubble is not pushed and retire_cnt does not increment for it.
- FIFO overflow: TRACE_DEPTH=4, retire 6 instrs with rd_en=0 -> full=1 after 4, overflow=1, retire_cnt=6, drain yields the first 4 in order then empty=1.
- Full simultaneous push and pop: FIFO full, rd_en=1 during a retire -> occupancy stays 4, overflow stays 0, new entry appears last.
- Saturation: CNT_W=4, run 20 cycles -> cycle_cnt holds 15.
